lfsr_rand_gen: RTL and testbench
================================

Name: lfsr_rand_gen

Overview:
- Parametrised successor to the team's fixed-width serial random-bit generator. A Fibonacci LFSR of configurable width (3..16) with built-in maximal-length taps.
- Adds a seed load with zero-seed protection, a step enable, and a serial-to-parallel word packer with a valid strobe.
- Sits beside test-pattern and dice/lottery logic in the synchronous sequential circuits set; it feeds either single random bits or OUT_W-bit random words to downstream logic.

Parameters:
- WIDTH, 5, LFSR register width; legal range 3..16; any other value must fail elaboration.
- OUT_W, 4, bits per packed output word; legal range 1..WIDTH.
- RST_SEED, 1, LFSR state after reset; must be nonzero and fit in WIDTH bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; asynchronous assert, active-low.
- load  in  1  synchronous seed load; takes priority over en.
- seed  in  WIDTH  seed value captured when load=1.
- en  in  1  advance LFSR one step per clock while high.
- state  out  WIDTH  current LFSR register.
- out  out  1  serial random bit, = state[WIDTH-1] (combinational from the register).
- word  out  OUT_W  packed random word.
- word_valid  out  1  one-cycle strobe; word is new.
- seed_err  out  1  sticky; set when a zero seed was loaded.
- period_done  out  1  see Optional Feature.

Behaviour:
- Reset (async, rst_n=0) values: state=RST_SEED, word=0, word_valid=0, seed_err=0, period_done=0, bit counter=0.
- Step rule: state <= {state[WIDTH-2:0], fb}. fb is the XOR of the tap bits (0-indexed) for the given WIDTH:
  - 3: 2,1; 4: 3,2; 5: 4,2; 6: 5,4; 7: 6,5; 8: 7,5,4,3
  - 9: 8,4; 10: 9,6; 11: 10,8; 12: 11,5,3,0
  - 13: 12,3,2,0; 14: 13,4,2,0; 15: 14,13; 16: 15,14,12,3
- Period is 2^WIDTH-1 for every nonzero seed.
- Priority per clock: load > en > hold.
- load=1, seed!=0: state<=seed, bit counter<=0, word_valid<=0.
- load=1, seed==0: state<=1, seed_err<=1, bit counter<=0.
- seed_err clears only on reset or on a later load of a nonzero seed.
- en=1, load=0: step the LFSR; the old out bit (pre-step state[WIDTH-1]) shifts into the packer shift register at LSB (MSB-first word); bit counter increments.
- When the counter reaches OUT_W-1 on an enabled step: word<=completed shift value, word_valid=1 in the next cycle for exactly one cycle, counter wraps to 0.
- en=0: state, counter and word hold; word_valid=0.
- Reset mid-word discards partial bits; the all-zero state is unreachable.

Optional Feature:
- Macro: LFSR_PERIOD_CHK_EN.
- Defined: a WIDTH-bit step counter tracks enabled steps since the last load/reset. When state returns to the value held after that load/reset, period_done pulses for one cycle and the counter clears. If the counter hits 2^WIDTH-1 without a match (impossible for correct taps), period_done does not pulse and seed_err is set.
- Undefined: counter logic absent; period_done tied to 0.

Test Plan:
- Reset with WIDTH=5, RST_SEED=1, en=0 -> state=5'h01, out=0, word_valid=0, seed_err=0, held indefinitely.
- load=1 seed=5'h01 then en=1 for 6 clocks -> state sequence 01,02,04,09,12,05,0B; out bits 0,0,0,0,1,0.
- OUT_W=4, en=1 from seed 5'h01 -> word_valid pulses on every 4th enabled step; first word=4'b0000, second word=4'b1001 (out bits 1,0,0,1 from states 12,05,0B,16).
- load=1 seed=0 -> state=5'h01, seed_err=1; then load seed=5'h03 -> seed_err=0.
- load and en high together with seed=5'h0A -> state=5'h0A (no step); en toggling low mid-word -> counter and word hold, no spurious word_valid.
- With LFSR_PERIOD_CHK_EN, WIDTH=5 seed=5'h01, en=1 -> period_done pulses after exactly 31 steps and again at 62; all 31 nonzero states seen once per period. With WIDTH=8 -> period 255.

Source files
------------

// File: rtl/lfsr_rand_gen.sv
// Parametrised Fibonacci LFSR random source with seed load, zero-seed guard and word packer.
// Optional period self-check is compiled in when LFSR_PERIOD_CHK_EN is defined.
module lfsr_rand_gen #(
  parameter int WIDTH    = 5,
  parameter int OUT_W    = 4,
  parameter int RST_SEED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  output logic [WIDTH-1:0] state,
  output logic             out,
  output logic [OUT_W-1:0] word,
  output logic             word_valid,
  output logic             seed_err,
  output logic             period_done
);

  function automatic logic [15:0] tap_mask(input int w);
    case (w)
      3:       tap_mask = 16'h0006;
      4:       tap_mask = 16'h000C;
      5:       tap_mask = 16'h0014;
      6:       tap_mask = 16'h0030;
      7:       tap_mask = 16'h0060;
      8:       tap_mask = 16'h00B8;
      9:       tap_mask = 16'h0110;
      10:      tap_mask = 16'h0240;
      11:      tap_mask = 16'h0500;
      12:      tap_mask = 16'h0829;
      13:      tap_mask = 16'h100D;
      14:      tap_mask = 16'h2015;
      15:      tap_mask = 16'h6000;
      16:      tap_mask = 16'hD008;
      default: tap_mask = 16'h0000;
    endcase
  endfunction

  generate
    if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
      $error("lfsr_rand_gen: WIDTH must be in 3..16");
    end
    if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
      $error("lfsr_rand_gen: OUT_W must be in 1..WIDTH");
    end
    if (RST_SEED <= 0 || RST_SEED >= (1 << WIDTH)) begin : g_bad_seed
      $error("lfsr_rand_gen: RST_SEED must be nonzero and fit in WIDTH bits");
    end
  endgenerate

  localparam logic [15:0]      TAP_FULL = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAP_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED0    = RST_SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam int               CW       = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(OUT_W - 1);

  logic [WIDTH-1:0] r_state;
  logic [CW-1:0]    r_cnt;
  logic [OUT_W-1:0] r_word;
  logic             r_valid;
  logic             r_err;

  logic             w_fb;
  logic             w_out;
  logic             w_step;
  logic [WIDTH-1:0] w_next;
  logic [OUT_W-1:0] w_shift_next;

  assign w_fb   = ^(r_state & TAPS);
  assign w_out  = r_state[WIDTH-1];
  assign w_next = {r_state[WIDTH-2:0], w_fb};
  assign w_step = en & ~load;

  // The bit about to leave the LFSR enters the packer at the LSB, so the word is MSB-first.
  generate
    if (OUT_W == 1) begin : g_pack1
      assign w_shift_next = w_out;
    end else begin : g_packn
      logic [OUT_W-2:0] r_shift;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_shift <= '0;
        end else if (w_step) begin
          r_shift <= w_shift_next[OUT_W-2:0];
        end
      end
      assign w_shift_next = {r_shift, w_out};
    end
  endgenerate

`ifdef LFSR_PERIOD_CHK_EN
  logic [WIDTH-1:0] r_ref;
  logic [WIDTH-1:0] r_steps;
  logic             r_pd;
  logic [WIDTH-1:0] w_steps_inc;
  assign w_steps_inc = r_steps + WIDTH'(1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED0;
      r_cnt   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
`ifdef LFSR_PERIOD_CHK_EN
      r_ref   <= SEED0;
      r_steps <= '0;
      r_pd    <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
`ifdef LFSR_PERIOD_CHK_EN
      r_pd    <= 1'b0;
`endif
      if (load) begin
        r_cnt <= '0;
        if (seed == '0) begin
          r_state <= ONE;
          r_err   <= 1'b1;
`ifdef LFSR_PERIOD_CHK_EN
          r_ref   <= ONE;
`endif
        end else begin
          r_state <= seed;
          r_err   <= 1'b0;
`ifdef LFSR_PERIOD_CHK_EN
          r_ref   <= seed;
`endif
        end
`ifdef LFSR_PERIOD_CHK_EN
        r_steps <= '0;
`endif
      end else if (en) begin
        r_state <= w_next;
        if (r_cnt == CNT_LAST) begin
          r_cnt   <= '0;
          r_word  <= w_shift_next;
          r_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
`ifdef LFSR_PERIOD_CHK_EN
        // Returning to the post-load state closes one period; a full count without a match means broken taps.
        if (w_next == r_ref) begin
          r_pd    <= 1'b1;
          r_steps <= '0;
        end else if (w_steps_inc == '1) begin
          r_err   <= 1'b1;
          r_steps <= '0;
        end else begin
          r_steps <= w_steps_inc;
        end
`endif
      end
    end
  end

  assign state      = r_state;
  assign out        = w_out;
  assign word       = r_word;
  assign word_valid = r_valid;
  assign seed_err   = r_err;
`ifdef LFSR_PERIOD_CHK_EN
  assign period_done = r_pd;
`else
  assign period_done = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Self-checking bench for lfsr_rand_gen: randomized stimulus against a behavioural bit-queue model.
// Period tests expect pulses only when LFSR_PERIOD_CHK_EN is defined.
module tb_lfsr_rand_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load, en;
  logic [4:0] seed;
  logic [4:0] state;
  logic       out;
  logic [3:0] word;
  logic       word_valid, seed_err, period_done;

  logic       load8, en8;
  logic [7:0] seed8;
  logic [7:0] state8;
  logic       out8;
  logic [7:0] word8;
  logic       word_valid8, seed_err8, period_done8;

  int n_vec = 0;
  int n_err = 0;

  int m_state, m_word, m_steps;
  bit m_valid, m_err, m_pd;
  int m_bits[$];

  logic [12:0] act_vec;
  assign act_vec = {state, out, word, word_valid, seed_err, period_done};

  always #5 clk = ~clk;

  lfsr_rand_gen #(.WIDTH(5), .OUT_W(4), .RST_SEED(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .load(load), .seed(seed), .en(en),
    .state(state), .out(out), .word(word), .word_valid(word_valid),
    .seed_err(seed_err), .period_done(period_done)
  );

  lfsr_rand_gen #(.WIDTH(8), .OUT_W(8), .RST_SEED(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .load(load8), .seed(seed8), .en(en8),
    .state(state8), .out(out8), .word(word8), .word_valid(word_valid8),
    .seed_err(seed_err8), .period_done(period_done8)
  );

  // Next state from the tap list: shift left, feed back the parity of the tapped bits.
  function automatic int lfsr_next(input int s, input int w);
    int taps[$];
    int fb;
    if (w == 5) taps = '{4, 2};
    else        taps = '{7, 5, 4, 3};
    fb = 0;
    foreach (taps[i]) fb ^= (s >> taps[i]) & 1;
    return ((s << 1) | fb) & ((1 << w) - 1);
  endfunction

  function automatic logic [12:0] exp_vec();
    logic [4:0] s;
    logic [3:0] w;
    s = 5'(m_state);
    w = 4'(m_word);
    return {s, s[4], w, m_valid, m_err, m_pd};
  endfunction

  task automatic model_reset();
    m_state = 1; m_word = 0; m_valid = 0; m_err = 0; m_pd = 0; m_steps = 0;
    m_bits.delete();
  endtask

  task automatic model_clk(input bit ld, input int sd, input bit e);
    m_valid = 0;
    m_pd    = 0;
    if (ld) begin
      m_bits.delete();
      m_steps = 0;
      if (sd == 0) begin m_state = 1;  m_err = 1; end
      else         begin m_state = sd; m_err = 0; end
    end else if (e) begin
      m_bits.push_back((m_state >> 4) & 1);
      m_state = lfsr_next(m_state, 5);
      if (m_bits.size() == 4) begin
        m_word = 0;
        foreach (m_bits[i]) m_word = (m_word << 1) | m_bits[i];
        m_valid = 1;
        m_bits.delete();
      end
`ifdef LFSR_PERIOD_CHK_EN
      m_steps++;
      if (m_steps == 31) begin m_pd = 1; m_steps = 0; end
`endif
    end
  endtask

  task automatic drive(input bit ld, input int sd, input bit e);
    load = ld; seed = 5'(sd); en = e;
    @(posedge clk);
    #1;
    model_clk(ld, sd, e);
    $display("t=%0t load=%b seed=%h en=%b -> state=%h out=%b word=%h valid=%b err=%b pd=%b",
             $time, ld, 5'(sd), e, state, out, word, word_valid, seed_err, period_done);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 0; en = 0; seed = 0;
    load8 = 0; en8 = 0; seed8 = 0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_vec++;
    if (act_vec !== exp_vec()) begin
      n_err++; $display("FAIL reset: got %h want %h", act_vec, exp_vec());
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0);
      n_vec++;
      if (act_vec !== exp_vec() || state !== 5'h01) begin
        n_err++; $display("FAIL reset_hold %0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_sequence();
    logic [4:0] exp_seq[6];
    logic       exp_out[6];
    logic       out_before;
    exp_seq = '{5'h02, 5'h04, 5'h09, 5'h12, 5'h05, 5'h0B};
    exp_out = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    drive(1, 1, 0);
    n_vec++;
    if (state !== 5'h01) begin
      n_err++; $display("FAIL seq_load: state %h want 01", state);
    end
    for (int i = 0; i < 6; i++) begin
      out_before = out;
      drive(0, 0, 1);
      n_vec++;
      if (act_vec !== exp_vec() || state !== exp_seq[i] || out_before !== exp_out[i]) begin
        n_err++;
        $display("FAIL seq step %0d: state %h out %b vec %h want state %h out %b vec %h",
                 i, state, out_before, act_vec, exp_seq[i], exp_out[i], exp_vec());
      end
    end
  endtask

  task automatic test_words();
    logic [3:0] words[$];
    drive(1, 1, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1);
      n_vec++;
      if (act_vec !== exp_vec()) begin
        n_err++; $display("FAIL words step %0d: got %h want %h", i, act_vec, exp_vec());
      end
      if (word_valid === 1'b1) words.push_back(word);
    end
    n_vec++;
    if (words.size() != 2) begin
      n_err++; $display("FAIL words_count: got %0d want 2", words.size());
    end else if (words[0] !== 4'b0000 || words[1] !== 4'b1001) begin
      n_err++; $display("FAIL words_value: got %b %b want 0000 1001", words[0], words[1]);
    end
  endtask

  task automatic test_zero_seed();
    drive(1, 0, 0);
    n_vec++;
    if (act_vec !== exp_vec() || state !== 5'h01 || seed_err !== 1'b1) begin
      n_err++; $display("FAIL zero_seed: got %h want %h", act_vec, exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1);
      n_vec++;
      if (act_vec !== exp_vec() || seed_err !== 1'b1) begin
        n_err++; $display("FAIL zero_seed_sticky %0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
    drive(1, 3, 0);
    n_vec++;
    if (act_vec !== exp_vec() || seed_err !== 1'b0 || state !== 5'h03) begin
      n_err++; $display("FAIL zero_seed_clear: got %h want %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_load_priority();
    drive(1, 3, 0);
    drive(0, 0, 1);
    drive(0, 0, 1);
    drive(1, 5'h0A, 1);
    n_vec++;
    if (act_vec !== exp_vec() || state !== 5'h0A || word_valid !== 1'b0) begin
      n_err++; $display("FAIL load_priority: got %h want %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_en_toggle();
    bit pattern[10];
    pattern = '{1, 1, 0, 0, 0, 1, 0, 1, 1, 0};
    drive(1, 1, 0);
    foreach (pattern[i]) begin
      drive(0, 0, pattern[i]);
      n_vec++;
      if (act_vec !== exp_vec()) begin
        n_err++; $display("FAIL en_toggle %0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    bit ld, e;
    int sd;
    for (int i = 0; i < 400; i++) begin
      ld = ($urandom % 32) == 0;
      e  = ($urandom % 4) != 0;
      sd = $urandom % 32;
      drive(ld, sd, e);
      n_vec++;
      if (act_vec !== exp_vec()) begin
        n_err++; $display("FAIL random %0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1, 5'h12, 0);
    drive(0, 0, 1);
    drive(0, 0, 1);
    load = 0; en = 0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (act_vec !== exp_vec()) begin
      n_err++; $display("FAIL async_reset: got %h want %h", act_vec, exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 1);
      n_vec++;
      if (act_vec !== exp_vec()) begin
        n_err++; $display("FAIL after_reset %0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_period();
    bit seen[32];
    int distinct;
    int pulses[$];
    drive(1, 1, 0);
    distinct = 0;
    foreach (seen[i]) seen[i] = 0;
    for (int k = 1; k <= 62; k++) begin
      drive(0, 0, 1);
      n_vec++;
      if (act_vec !== exp_vec()) begin
        n_err++; $display("FAIL period step %0d: got %h want %h", k, act_vec, exp_vec());
      end
      if (period_done === 1'b1) pulses.push_back(k);
      if (k <= 31 && !seen[state]) begin seen[state] = 1; distinct++; end
    end
    n_vec++;
    if (distinct != 31 || seen[0]) begin
      n_err++; $display("FAIL period_states: got %0d distinct zero_seen=%b want 31 and 0", distinct, seen[0]);
    end
    n_vec++;
`ifdef LFSR_PERIOD_CHK_EN
    if (pulses.size() != 2 || pulses[0] != 31 || pulses[1] != 62) begin
      n_err++; $display("FAIL period_pulses: got %0d pulses want 2 at steps 31 and 62", pulses.size());
    end
`else
    if (pulses.size() != 0) begin
      n_err++; $display("FAIL period_pulses: got %0d pulses want 0", pulses.size());
    end
`endif
  endtask

  task automatic test_width8();
    int  ms;
    bit  exp_pd;
    load8 = 1; seed8 = 8'h01; en8 = 0;
    @(posedge clk);
    #1;
    load8 = 0;
    ms = 1;
    n_vec++;
    if (state8 !== 8'h01) begin
      n_err++; $display("FAIL w8_load: state %h want 01", state8);
    end
    en8 = 1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      ms = lfsr_next(ms, 8);
`ifdef LFSR_PERIOD_CHK_EN
      exp_pd = (k % 255) == 0;
`else
      exp_pd = 0;
`endif
      $display("t=%0t w8 step %0d -> state=%h pd=%b", $time, k, state8, period_done8);
      n_vec++;
      if (state8 !== 8'(ms) || period_done8 !== exp_pd || seed_err8 !== 1'b0) begin
        n_err++;
        $display("FAIL w8 step %0d: state %h pd %b err %b want state %h pd %b err 0",
                 k, state8, period_done8, seed_err8, 8'(ms), exp_pd);
      end
    end
    en8 = 0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_words();
    test_zero_seed();
    test_load_priority();
    test_en_toggle();
    test_random();
    test_async_reset();
    test_period();
    test_width8();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
